inst_fetch: RTL and testbench

//  Producer of the 32-bit instruction word consumed by the decoder. Holds the PC, issues
//  in-order word reads to instruction memory, buffers returned words in a small FIFO and

---
 rtl/inst_fetch.sv | 127 ++++++++++++
 tb/tb_inst_fetch.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch: PC, in-order imem reads, output FIFO, redirect/drain
// Optional: define FETCH_MISALIGN_EN to add the sticky fetch_misalign output.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        code_valid,
  input  logic        code_ready,
  output logic [31:0] code,
  output logic [31:0] code_pc
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam logic [PW-1:0]  PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW1-1:0] DEPTH_W  = CW1'(FIFO_DEPTH);
  localparam logic [31:0]    NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc   [FIFO_DEPTH];

  logic           w_rsp_take;
  logic           w_accept;
  logic           w_push;
  logic           w_pop;
  logic           w_block;
  logic [CW-1:0]  w_out_after;
  logic [CW1-1:0] w_inflight;
  logic [31:0]    w_rsp_pc;
  logic [31:0]    w_target;

`ifdef FETCH_MISALIGN_EN
  logic r_misalign;
  assign w_block        = r_misalign;
  assign fetch_misalign = r_misalign;
  assign w_target       = redirect_pc;
`else
  assign w_block  = 1'b0;
  assign w_target = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign w_rsp_take  = imem_rsp_valid && (r_outstanding != '0);
  assign w_out_after = r_outstanding - CW'(w_rsp_take);
  assign w_inflight  = {1'b0, r_outstanding} + {1'b0, r_count};

  assign imem_req_valid = (r_state == S_RUN) && !redirect_valid && !w_block &&
                          (w_inflight < DEPTH_W);
  assign imem_req_addr  = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  // All outstanding requests are consecutive words ending just below r_pc.
  assign w_rsp_pc = r_pc - (32'(r_outstanding) << 2);
  assign w_push   = w_rsp_take && (r_state == S_RUN) && !redirect_valid;

  assign code_valid = (r_count != '0);
  assign w_pop      = code_valid && code_ready && !redirect_valid;
  assign code       = code_valid ? r_fifo_data[r_rd_ptr] : NOP;
  assign code_pc    = code_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
`ifdef FETCH_MISALIGN_EN
      r_misalign    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE:  r_state <= S_RUN;
        S_RUN:   if (redirect_valid && (w_out_after != '0)) r_state <= S_DRAIN;
        S_DRAIN: if (!redirect_valid && (w_out_after == '0)) r_state <= S_RUN;
        default: r_state <= S_IDLE;
      endcase

      r_outstanding <= w_out_after + CW'(w_accept);

      if (redirect_valid) begin
        r_pc     <= w_target;
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
`ifdef FETCH_MISALIGN_EN
        r_misalign <= (redirect_pc[1:0] != 2'b00);
`endif
      end else begin
        if (w_accept) r_pc <= r_pc + 32'd4;
        if (w_push)   r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
        if (w_pop)    r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= imem_rsp_data;
      r_fifo_pc[r_wr_ptr]   <= w_rsp_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch against a queue-level fetch model
// Honours FETCH_MISALIGN_EN when defined.
module tb_inst_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        code_valid;
  logic        code_ready = 1'b1;
  logic [31:0] code;
  logic [31:0] code_pc;
`ifdef FETCH_MISALIGN_EN
  logic        fetch_misalign;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .code_valid(code_valid), .code_ready(code_ready),
    .code(code), .code_pc(code_pc)
`ifdef FETCH_MISALIGN_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Memory: in-order responses, each exactly mem_lat cycles after acceptance.
  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int    cyc = 0;
  int    mem_lat = 1;

  always @(posedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      mq.delete();
      imem_rsp_valid = 1'b0;
    end else if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].a);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
  end

  // Fetch model: next pc, outstanding addresses, buffered words, drain flag.
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] q_out[$];
  logic [63:0] q_fifo[$];
  logic        m_drain = 1'b0;
  logic        m_started = 1'b0;
  logic        m_misalign = 1'b0;
  logic [31:0] log_req[$];
  int          log_req_cyc[$];
  logic [31:0] log_pop_pc[$];
  logic [31:0] log_pop_data[$];
  int          log_pop_cyc[$];

  always @(negedge clk) begin : cmp
    logic        exp_req;
    logic        exp_cv;
    logic [31:0] a;
    mreq_t       e;
    #1;
    if (rst) begin
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_code_valid", 32'(code_valid), 32'd0);
      check("rst_code", code, NOP);
      check("rst_code_pc", code_pc, 32'h0);
`ifdef FETCH_MISALIGN_EN
      check("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif
      m_pc = RESET_PC;
      q_out.delete();
      q_fifo.delete();
      mq.delete();
      m_drain = 1'b0;
      m_started = 1'b0;
      m_misalign = 1'b0;
    end else begin
      exp_req = m_started && !m_drain && !m_misalign && !redirect_valid &&
                (q_out.size() + q_fifo.size() < DEPTH);
      exp_cv  = (q_fifo.size() != 0);
      check("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) check("req_addr", imem_req_addr, m_pc);
      check("code_valid", 32'(code_valid), 32'(exp_cv));
      check("code", code, exp_cv ? q_fifo[0][63:32] : NOP);
      check("code_pc", code_pc, exp_cv ? q_fifo[0][31:0] : 32'h0);
`ifdef FETCH_MISALIGN_EN
      check("fetch_misalign", 32'(fetch_misalign), 32'(m_misalign));
`endif
      if (imem_rsp_valid && q_out.size() != 0) begin
        a = q_out.pop_front();
        if (!m_drain && !redirect_valid) q_fifo.push_back({mem_word(a), a});
      end
      if (exp_cv && code_ready && !redirect_valid) begin
        log_pop_pc.push_back(q_fifo[0][31:0]);
        log_pop_data.push_back(q_fifo[0][63:32]);
        log_pop_cyc.push_back(cyc);
        void'(q_fifo.pop_front());
      end
      if (exp_req && imem_req_ready) begin
        log_req.push_back(m_pc);
        log_req_cyc.push_back(cyc);
        q_out.push_back(m_pc);
        e.a   = m_pc;
        e.due = cyc + mem_lat;
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
      if (redirect_valid) begin
        q_fifo.delete();
`ifdef FETCH_MISALIGN_EN
        m_pc       = redirect_pc;
        m_misalign = (redirect_pc[1:0] != 2'b00);
`else
        m_pc = {redirect_pc[31:2], 2'b00};
`endif
        if (q_out.size() != 0) m_drain = 1'b1;
      end else if (m_drain && q_out.size() == 0) begin
        m_drain = 1'b0;
      end
      m_started = 1'b1;
    end
  end

  task automatic redirect_to(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_outstanding2(input string nm);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (q_out.size() == 2) begin
        found = 1'b1;
        break;
      end
    end
    check(nm, 32'(found), 32'd1);
  endtask

  initial begin
    int   mr;
    int   mp;
    logic found;
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   mr;
    int   mp;
    logic found;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: sequential fetch from reset
    repeat (12) @(negedge clk);
    check("t1_nreq", 32'(log_req.size() >= 3), 32'd1);
    check("t1_addr0", log_req[0], 32'h0);
    check("t1_addr1", log_req[1], 32'h4);
    check("t1_addr2", log_req[2], 32'h8);
    check("t1_npop", 32'(log_pop_pc.size() >= 2), 32'd1);
    check("t1_pop_pc0", log_pop_pc[0], 32'h0);
    check("t1_pop_pc1", log_pop_pc[1], 32'h4);
    check("t1_pop_data0", log_pop_data[0], 32'hC0DE_0000);
    check("t1_pop_data1", log_pop_data[1], 32'hC0DE_0004);
    check("t1_latency", 32'(log_pop_cyc[0] - log_req_cyc[0]), 32'd2);

    // 2: decoder stalled -> only DEPTH requests, then ordered release
    mr = log_req.size();
    mp = log_pop_pc.size();
    code_ready = 1'b0;
    redirect_to(32'h40);
    repeat (9) @(negedge clk);
    check("t2_nreq", 32'(log_req.size() - mr), 32'd2);
    check("t2_addr0", log_req[mr], 32'h40);
    check("t2_addr1", log_req[mr+1], 32'h44);
    check("t2_req_blocked", 32'(imem_req_valid), 32'd0);
    check("t2_code_valid", 32'(code_valid), 32'd1);
    check("t2_code_pc", code_pc, 32'h40);
    code_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("t2_npop", 32'(log_pop_pc.size() - mp >= 3), 32'd1);
    check("t2_pop0", log_pop_pc[mp], 32'h40);
    check("t2_pop1", log_pop_pc[mp+1], 32'h44);
    check("t2_pop2", log_pop_pc[mp+2], 32'h48);

    // 3: redirect with two outstanding -> drain
    mem_lat = 3;
    wait_outstanding2("t3_two_outstanding");
    mr = log_req.size();
    mp = log_pop_pc.size();
    redirect_to(32'h100);
    repeat (15) @(negedge clk);
    check("t3_nreq", 32'(log_req.size() > mr), 32'd1);
    check("t3_addr", log_req[mr], 32'h100);
    check("t3_npop", 32'(log_pop_pc.size() > mp), 32'd1);
    check("t3_pop_pc", log_pop_pc[mp], 32'h100);
    check("t3_pop_data", log_pop_data[mp], 32'hC0DE_0100);

    // 4: redirect together with a response and a consuming decoder
    mem_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (imem_rsp_valid && code_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_rsp_and_valid", 32'(found), 32'd1);
    mp = log_pop_pc.size();
    code_ready = 1'b1;
    redirect_to(32'h300);
    check("t4_code_valid_after", 32'(code_valid), 32'd0);
    check("t4_no_pop", 32'(log_pop_pc.size()), 32'(mp));
    repeat (8) @(negedge clk);
    check("t4_pop_pc", log_pop_pc[mp], 32'h300);

    // 5: pc wrap, then reset in the middle of a drain
    mr = log_req.size();
    redirect_to(32'hFFFF_FFF8);
    repeat (12) @(negedge clk);
    check("t5_nreq", 32'(log_req.size() - mr >= 3), 32'd1);
    check("t5_addr0", log_req[mr], 32'hFFFF_FFF8);
    check("t5_addr1", log_req[mr+1], 32'hFFFF_FFFC);
    check("t5_addr2", log_req[mr+2], 32'h0000_0000);
    mem_lat = 3;
    wait_outstanding2("t5_two_outstanding");
    redirect_to(32'h500);
    check("t5_in_drain", 32'(q_out.size() != 0), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t5_async_req_valid", 32'(imem_req_valid), 32'd0);
    check("t5_async_code_valid", 32'(code_valid), 32'd0);
    check("t5_async_code", code, NOP);
    check("t5_async_code_pc", code_pc, 32'h0);
    @(negedge clk);
    @(negedge clk);
    mem_lat = 1;
    mr = log_req.size();
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_restart_nreq", 32'(log_req.size() > mr), 32'd1);
    check("t5_restart_addr", log_req[mr], RESET_PC);

    // 6: misaligned redirect target
    mr = log_req.size();
    mp = log_pop_pc.size();
    redirect_to(32'h102);
    repeat (8) @(negedge clk);
`ifdef FETCH_MISALIGN_EN
    check("t6_no_req", 32'(log_req.size()), 32'(mr));
    check("t6_misalign_set", 32'(fetch_misalign), 32'd1);
    redirect_to(32'h200);
    repeat (6) @(negedge clk);
    check("t6_misalign_clr", 32'(fetch_misalign), 32'd0);
    check("t6_resume_addr", log_req[mr], 32'h200);
`else
    check("t6_nreq", 32'(log_req.size() > mr), 32'd1);
    check("t6_forced_addr", log_req[mr], 32'h100);
    check("t6_pop_pc", log_pop_pc[mp], 32'h100);
`endif

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
